// File: rtl/nfi_controller.sv
// Pacing controller for the NFI engine: one-cycle o_go strobe every MAX_CNT allowed cycles.
// Optional build macro NFI_CLEAR_ON_PAUSE_EN: a paused cycle restarts the count from zero.
module nfi_controller #(
   parameter int MAX_CNT = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_NFI_allowed,
   output logic o_go
);

   localparam int CW = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   generate
      if (MAX_CNT < 1) begin : g_bad_max_cnt
         $error("nfi_controller: MAX_CNT must be >= 1");
      end
   endgenerate

   // FIRE is the only encoding with bit 1 set, so o_go comes straight off a flop.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COUNT = 2'b01,
      FIRE  = 2'b10
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          wrap;

   assign wrap = (cnt_reg == CW'(MAX_CNT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      cnt_next   = cnt_reg;
      state_next = IDLE;
      if (i_NFI_allowed) begin
         if (wrap) begin
            cnt_next   = '0;
            state_next = FIRE;
         end else begin
            cnt_next   = cnt_reg + CW'(1);
            state_next = COUNT;
         end
      end else begin
`ifdef NFI_CLEAR_ON_PAUSE_EN
         cnt_next   = '0;
         state_next = IDLE;
`else
         state_next = (cnt_reg == '0) ? IDLE : COUNT;
`endif
      end
   end

   assign o_go = state_reg[1];

endmodule

// File: tb/tb_nfi_controller.sv
// Self-checking bench for nfi_controller: MAX_CNT=10 and MAX_CNT=1 instances share one allow input.
// Honours NFI_CLEAR_ON_PAUSE_EN when defined for the build.
module tb_nfi_controller;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic allowed = 1'b0;
   logic go10, go1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   nfi_controller #(.MAX_CNT(10)) dut10 (
      .clk(clk), .rst_n(rst_n), .i_NFI_allowed(allowed), .o_go(go10)
   );
   nfi_controller #(.MAX_CNT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .i_NFI_allowed(allowed), .o_go(go1)
   );

   // Model: number of allowed samples since reset or last strobe; strobe when it reaches 10.
   // The MAX_CNT=1 instance is simply the allow level delayed by one edge.
   int   m_seen = 0;
   logic m_go10 = 1'b0;
   logic m_go1 = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_seen <= 0;
         m_go10 <= 1'b0;
         m_go1  <= 1'b0;
      end else begin
         m_go1 <= allowed;
         if (allowed) begin
            if (m_seen + 1 == 10) begin
               m_seen <= 0;
               m_go10 <= 1'b1;
            end else begin
               m_seen <= m_seen + 1;
               m_go10 <= 1'b0;
            end
         end else begin
            m_go10 <= 1'b0;
`ifdef NFI_CLEAR_ON_PAUSE_EN
            m_seen <= 0;
`endif
         end
      end
   end

   task automatic check(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check("model_go10", go10, m_go10);
         check("model_go1", go1, m_go1);
      end
   end

   task automatic step(input logic a);
      allowed = a;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #1;
      check("async_rst_go10", go10, 1'b0);
      check("async_rst_go1", go1, 1'b0);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int target;
      // 1: short reset pulse, then 50 idle cycles
      #1 rst_n = 1'b0;
      #2 check("reset_go10", go10, 1'b0);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 50; i++) step(1'b0);
      check("idle50_go10", go10, 1'b0);
      $display("txn idle: 50 cycles with allow low");

      // 2: continuous allow, strobe after edges 10, 20, 30
      for (int k = 1; k <= 30; k++) begin
         step(1'b1);
         check("cont_go10", go10, (k % 10) == 0);
         check("cont_go1", go1, 1'b1);
      end
      $display("txn continuous: 30 allowed edges");

      // 3: 8 allowed, 2 paused, then re-allow
`ifdef NFI_CLEAR_ON_PAUSE_EN
      target = 10;
`else
      target = 2;
`endif
      for (int k = 0; k < 8; k++) step(1'b1);
      step(1'b0);
      check("pause_go1_low", go1, 1'b0);
      step(1'b0);
      for (int j = 1; j <= 10; j++) begin
         step(1'b1);
         check("pause_resume_go10", go10, j == target);
      end
      $display("txn pause: strobe expected on re-allowed edge %0d", target);

      // 4: async reset mid-count, then a full period is needed again
      reset_pulse();
      for (int k = 0; k < 6; k++) step(1'b1);
      reset_pulse();
      for (int k = 1; k <= 10; k++) begin
         step(1'b1);
         check("post_rst_go10", go10, k == 10);
      end
      reset_pulse();
      check("rst_while_high_go10", go10, 1'b0);
      $display("txn reset: mid-count and during strobe");

      // 5: allow drops right after the wrap edge
      for (int k = 1; k <= 9; k++) step(1'b1);
      step(1'b1);
      allowed = 1'b0;
      check("drop_at_wrap_go10", go10, 1'b1);
      for (int k = 0; k < 5; k++) begin
         step(1'b0);
         check("drop_after_go10", go10, 1'b0);
      end
      $display("txn drop at wrap: single strobe then quiet");

      // 6: MAX_CNT=1 follows allow one edge late
      reset_pulse();
      step(1'b0);
      check("m1_idle", go1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1'b1);
         check("m1_allow", go1, 1'b1);
      end
      step(1'b0);
      check("m1_fall", go1, 1'b0);
      step(1'b0);
      check("m1_stay_low", go1, 1'b0);
      $display("txn max_cnt1: level follows allow");

      @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
